// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Groups the decode-side controls and the PC/RAS status outputs of
//   pc_sequencer. CLK and Resetb stay plain ports on the module.
//
//   master : decode stage / testbench. Drives controls, observes PC and RAS.
//   slave  : pc_sequencer. Consumes controls, drives PC and RAS status.
//
//   Controls (master -> slave)
//     Stall, Branch, BranchNE, ALUZero, Jump, JumpReg, Link
//     JumpField[25:0], SignExtImm[AW-1:0], RegTarget[AW-1:0]
//   Status (slave -> master)
//     CurrentPC[AW-1:0], PCPlus4[AW-1:0], RasCount[4:0]
//     RasMismatch, RasOverflow
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  Stall;
  logic                  Branch;
  logic                  BranchNE;
  logic                  ALUZero;
  logic                  Jump;
  logic                  JumpReg;
  logic                  Link;
  logic [25:0]           JumpField;
  logic [ADDR_WIDTH-1:0] SignExtImm;
  logic [ADDR_WIDTH-1:0] RegTarget;
  logic [ADDR_WIDTH-1:0] CurrentPC;
  logic [ADDR_WIDTH-1:0] PCPlus4;
  logic [4:0]            RasCount;
  logic                  RasMismatch;
  logic                  RasOverflow;

  modport master (
    output Stall, Branch, BranchNE, ALUZero, Jump, JumpReg, Link,
           JumpField, SignExtImm, RegTarget,
    input  CurrentPC, PCPlus4, RasCount, RasMismatch, RasOverflow
  );

  modport slave (
    input  Stall, Branch, BranchNE, ALUZero, Jump, JumpReg, Link,
           JumpField, SignExtImm, RegTarget,
    output CurrentPC, PCPlus4, RasCount, RasMismatch, RasOverflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Registered program counter for the MIPS datapath. Each rising CLK edge
//   loads the next PC, chosen by priority: JR/JALR, J/JAL, taken branch,
//   sequential. A circular return-address stack (RAS) shadows call depth and
//   flags JR targets that disagree with the recorded return address; the
//   flag is diagnostic and never alters the PC.
//
//   Ports
//     CLK     in   rising-edge clock
//     Resetb  in   synchronous active-low reset
//     bus     pc_sequencer_if.slave: decode controls in, PC/RAS status out
//
//   Parameters
//     ADDR_WIDTH  PC width, 30..32
//     RESET_PC    PC loaded on reset, word aligned
//     RAS_DEPTH   return-stack entries, 2..16
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int                  RAS_DEPTH  = 4
) (
  input  logic           CLK,
  input  logic           Resetb,
  pc_sequencer_if.slave  bus
);

  localparam int                   PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [4:0]           DEPTH_CNT = 5'(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  // Architectural state
  logic [ADDR_WIDTH-1:0] currentPc;
  logic [4:0]            rasCount;
  logic [PTR_W-1:0]      topIdx;
  logic                  rasMismatch;
  logic                  rasOverflow;
  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];

  // Next-PC datapath
  logic [ADDR_WIDTH-1:0] pcPlus4;
  logic [ADDR_WIDTH-1:0] regJumpTarget;
  logic [ADDR_WIDTH-1:0] jumpTarget;
  logic [ADDR_WIDTH-1:0] branchTarget;
  logic [ADDR_WIDTH-1:0] nextPc;
  logic                  taken;

  assign pcPlus4       = currentPc + PC_STEP;
  assign regJumpTarget = bus.RegTarget & WORD_MASK;
  // Region bits come from PC+4 so a jump in the last slot of a 256 MB
  // region lands in the following region.
  assign jumpTarget    = {pcPlus4[ADDR_WIDTH-1:28], bus.JumpField, 2'b00};
  assign branchTarget  = pcPlus4 + (bus.SignExtImm << 2);
  assign taken         = bus.Branch & (bus.ALUZero ^ bus.BranchNE);

  always_comb begin
    nextPc = pcPlus4;
    if (bus.JumpReg)   nextPc = regJumpTarget;
    else if (bus.Jump) nextPc = jumpTarget;
    else if (taken)    nextPc = branchTarget;
  end

  // RAS control
  logic                  isJal;
  logic                  rasEmpty;
  logic                  rasFull;
  logic [PTR_W-1:0]      incIdx;
  logic [PTR_W-1:0]      decIdx;
  logic [ADDR_WIDTH-1:0] topEntry;

  logic                  rasWe;
  logic [PTR_W-1:0]      rasWIdx;
  logic [PTR_W-1:0]      nextTopIdx;
  logic [4:0]            nextCount;
  logic                  nextOverflow;
  logic                  nextMismatch;

  assign isJal    = bus.Jump & bus.Link & ~bus.JumpReg;
  assign rasEmpty = (rasCount == 5'd0);
  assign rasFull  = (rasCount == DEPTH_CNT);
  // Explicit wrap keeps non-power-of-two depths circular.
  assign incIdx   = (topIdx == LAST_IDX) ? '0 : topIdx + PTR_W'(1);
  assign decIdx   = (topIdx == '0) ? LAST_IDX : topIdx - PTR_W'(1);
  assign topEntry = ras[topIdx];

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    rasWe        = 1'b0;
    rasWIdx      = topIdx;
    nextTopIdx   = topIdx;
    nextCount    = rasCount;
    nextOverflow = rasOverflow;
    nextMismatch = 1'b0;

    if (!bus.Stall) begin
      if (isJal) begin
        // A push on a full stack overwrites the oldest slot.
        rasWe      = 1'b1;
        rasWIdx    = incIdx;
        nextTopIdx = incIdx;
        if (rasFull) nextOverflow = 1'b1;
        else         nextCount    = rasCount + 5'd1;
      end else if (bus.JumpReg) begin
        if (!rasEmpty) nextMismatch = (regJumpTarget != topEntry);
        if (bus.Link) begin
          // JALR: replace the top in place, or push onto an empty stack.
          rasWe = 1'b1;
          if (rasEmpty) begin
            rasWIdx    = incIdx;
            nextTopIdx = incIdx;
            nextCount  = 5'd1;
          end
        end else if (!rasEmpty) begin
          nextTopIdx = decIdx;
          nextCount  = rasCount - 5'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!Resetb) begin
      currentPc   <= RESET_PC;
      rasCount    <= 5'd0;
      topIdx      <= '0;
      rasMismatch <= 1'b0;
      rasOverflow <= 1'b0;
    end else begin
      if (!bus.Stall) currentPc <= nextPc;
      rasCount    <= nextCount;
      topIdx      <= nextTopIdx;
      rasMismatch <= nextMismatch;
      rasOverflow <= nextOverflow;
    end
  end

  // NOTE: stack storage has no reset; RasCount alone decides which entries
  // are meaningful, so it maps onto plain register/RAM cells.
  always_ff @(posedge CLK) begin
    if (Resetb && rasWe) ras[rasWIdx] <= pcPlus4;
  end

  assign bus.CurrentPC   = currentPc;
  assign bus.PCPlus4     = pcPlus4;
  assign bus.RasCount    = rasCount;
  assign bus.RasMismatch = rasMismatch;
  assign bus.RasOverflow = rasOverflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed stimulus for pc_sequencer (RESET_PC=0x400, RAS_DEPTH=4). Each
//   driven cycle queues the hand-computed state expected after that edge;
//   a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk;
  logic resetb;

  pc_sequencer_if #(.ADDR_WIDTH(32)) bus ();

  pc_sequencer #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0400),
    .RAS_DEPTH  (4)
  ) dut (
    .CLK    (clk),
    .Resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [4:0]  cnt;
    logic        mis;
    logic        ovf;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one queued expectation per edge, compared mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      check({e.name, ".pc"},    bus.CurrentPC,            e.pc);
      check({e.name, ".pc4"},   bus.PCPlus4,              e.pc + 32'd4);
      check({e.name, ".cnt"},   32'(bus.RasCount),        32'(e.cnt));
      check({e.name, ".mis"},   32'(bus.RasMismatch),     32'(e.mis));
      check({e.name, ".ovf"},   32'(bus.RasOverflow),     32'(e.ovf));
    end
  end

  task automatic step(input string name, input logic [31:0] pc, input logic [4:0] cnt,
                      input logic mis, input logic ovf);
    expT e;
    e.name = name; e.pc = pc; e.cnt = cnt; e.mis = mis; e.ovf = ovf;
    @(posedge clk);
    #1;
    expQ.push_back(e);
  endtask

  task automatic idle();
    bus.Stall = 1'b0; bus.Branch = 1'b0; bus.BranchNE = 1'b0; bus.ALUZero = 1'b0;
    bus.Jump = 1'b0; bus.JumpReg = 1'b0; bus.Link = 1'b0;
    bus.JumpField = '0; bus.SignExtImm = '0; bus.RegTarget = '0;
  endtask

  task automatic doJr(input logic [31:0] rt);
    idle(); bus.JumpReg = 1'b1; bus.RegTarget = rt;
  endtask

  task automatic doJalr(input logic [31:0] rt);
    idle(); bus.JumpReg = 1'b1; bus.Link = 1'b1; bus.RegTarget = rt;
  endtask

  task automatic doJal(input logic [25:0] jf);
    idle(); bus.Jump = 1'b1; bus.Link = 1'b1; bus.JumpField = jf;
  endtask

  task automatic doBranch(input logic bne, input logic zero, input logic [31:0] imm);
    idle(); bus.Branch = 1'b1; bus.BranchNE = bne; bus.ALUZero = zero; bus.SignExtImm = imm;
  endtask

  initial begin
    resetb = 1'b0;
    idle();
    step("reset", 32'h400, 0, 0, 0);

    resetb = 1'b1;
    step("seq1", 32'h404, 0, 0, 0);
    step("seq2", 32'h408, 0, 0, 0);

    // Conditional branches from PC 0x10
    doJr(32'h10);                      step("jr_empty",      32'h10, 0, 0, 0);
    doBranch(0, 1, 32'hFFFF_FFFF);     step("beq_back",      32'h10, 0, 0, 0);
    doBranch(1, 1, 32'hFFFF_FFFF);     step("bne_not_taken", 32'h14, 0, 0, 0);
    doJr(32'h10);                      step("jr_back",       32'h10, 0, 0, 0);
    doBranch(0, 1, 32'h1);             step("beq_fwd",       32'h18, 0, 0, 0);
    doBranch(1, 0, 32'h20);            step("bne_taken",     32'h9C, 0, 0, 0);

    // Jumps: region bits from PC+4; unaligned RegTarget is word-aligned
    doJr(32'h8FFF_FFFF);               step("jr_align",      32'h8FFF_FFFC, 0, 0, 0);
    idle(); bus.Jump = 1'b1; bus.JumpField = 26'h100;
    bus.Branch = 1'b1; bus.ALUZero = 1'b1; bus.SignExtImm = 32'h5;
                                       step("j_region",      32'h9000_0400, 0, 0, 0);
    doJr(32'hFFFF_FFF0);               step("jr_hi",         32'hFFFF_FFF0, 0, 0, 0);
    idle(); bus.Jump = 1'b1; bus.JumpField = 26'h0;
                                       step("j_top",         32'hF000_0000, 0, 0, 0);
    doJr(32'hFFFF_FFFC);               step("jr_last",       32'hFFFF_FFFC, 0, 0, 0);
    idle();                            step("wrap",          32'h0, 0, 0, 0);

    // JumpReg beats Jump for both PC and RAS
    doJr(32'h100); bus.Jump = 1'b1; bus.Link = 1'b0; bus.JumpField = 26'h3FF;
                                       step("jr_over_j",     32'h100, 0, 0, 0);

    // Call/return, matching then mismatching
    doJal(26'h40);                     step("jal1",          32'h100, 1, 0, 0);
    doJr(32'h104);                     step("jr_match",      32'h104, 0, 0, 0);
    idle();                            step("after_match",   32'h108, 0, 0, 0);
    doJr(32'h100);                     step("jr_reseat",     32'h100, 0, 0, 0);
    doJal(26'h40);                     step("jal2",          32'h100, 1, 0, 0);
    doJr(32'h200);                     step("jr_mismatch",   32'h200, 0, 1, 0);
    idle();                            step("mis_pulse_end", 32'h204, 0, 0, 0);

    // Five calls into a 4-deep stack, then four LIFO returns
    doJal(26'h400);                    step("push1",         32'h1000, 1, 0, 0);
    doJal(26'h800);                    step("push2",         32'h2000, 2, 0, 0);
    doJal(26'hC00);                    step("push3",         32'h3000, 3, 0, 0);
    doJal(26'h1000);                   step("push4",         32'h4000, 4, 0, 0);
    doJal(26'h1400);                   step("push5_ovf",     32'h5000, 4, 0, 1);
    doJr(32'h4004);                    step("pop1",          32'h4004, 3, 0, 1);
    doJr(32'h3004);                    step("pop2",          32'h3004, 2, 0, 1);
    doJr(32'h2004);                    step("pop3",          32'h2004, 1, 0, 1);
    doJr(32'h1004);                    step("pop4",          32'h1004, 0, 0, 1);
    doJr(32'h500);                     step("pop_empty",     32'h500, 0, 0, 1);

    // JALR: push on empty, then compare-and-replace top
    doJalr(32'h600);                   step("jalr_empty",    32'h600, 1, 0, 1);
    doJalr(32'h700);                   step("jalr_replace",  32'h700, 1, 1, 1);
    doJr(32'h604);                     step("jr_after_jalr", 32'h604, 0, 0, 1);

    // Stall during a JAL, then reset while still stalled
    doJal(26'h300); bus.Stall = 1'b1;
    step("stall1", 32'h604, 0, 0, 1);
    step("stall2", 32'h604, 0, 0, 1);
    step("stall3", 32'h604, 0, 0, 1);
    resetb = 1'b0;                     step("reset_in_stall", 32'h400, 0, 0, 0);
    resetb = 1'b1; idle();             step("post_reset",     32'h404, 0, 0, 0);

    // Bounded drain of the scoreboard
    repeat (3) @(negedge clk);
    #1;
    check("drain", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
